dmem_arbiter: RTL
=================

# dmem_arbiter

Shares the single-port data RAM (512 x 32, combinational read, write on rising clock edge) between two requesters. Port 0 is the rv32i core's load/store path. Port 1 is the program/debug loader. Arbitration is round-robin with a bounded burst. Each granted access takes exactly one RAM cycle, and read data comes back on a registered return path.

## Interface
- ADDR_W, 9, word-address width driven to the RAM (512 words)
- BURST, 4, max consecutive grants to one port while the other port is waiting (>=1)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req0 / req1  in  1  access request; held high until the matching gnt
- we0 / we1  in  1  1 = write, 0 = read; valid while req is high
- addr0 / addr1  in  ADDR_W  word address
- wdata0 / wdata1  in  32  write data
- gnt0 / gnt1  out  1  combinational; access is performed this cycle
- rvalid0 / rvalid1  out  1  registered; read data valid, one-cycle pulse
- rdata0 / rdata1  out  32  registered read data; holds until that port's next read completes
- ram_read  out  1  RAM read enable
- ram_write  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data (combinational from ram_addr)

## Operation
- State: fsm in {IDLE, OWN0, OWN1}; cnt (width clog2(BURST)+1) counts consecutive grants to the owner; last = port granted most recently.
- IDLE:
  - Only one req high: grant it.
  - Both high: grant the port != last.
  - After a grant: go to OWNx with cnt=1. No req: stay in IDLE.
- OWNx, with y = the other port:
  - reqx && (cnt<BURST || !reqy): grant x, cnt = min(cnt+1, BURST).
  - Else if reqy: grant y, go to OWNy, cnt=1.
  - Else (no req): no grant, go to IDLE, cnt=0.
- At most one gnt is high per cycle. gnt0 & gnt1 is never 1.
- RAM drive:
  - ram_read = gnt & ~we of the granted port; ram_write = gnt & we of the granted port.
  - ram_addr and ram_wdata are muxed from the granted port.
  - With no grant, all four RAM outputs are 0.
- Read return: on a granted read by port x, at the next clock edge rdatax <= ram_rdata and rvalidx <= 1. Otherwise rvalidx <= 0.
- Writes produce no rvalid.
- A requester drops or changes req only after seeing gnt. The arbiter never grants a port whose req is low.

## Timing
- Reset (async, immediate): fsm=IDLE, cnt=0, last=1 (port 0 wins the first tie), rvalid0=rvalid1=0, rdata0=rdata1=0. gnt and RAM outputs are 0 while rst is high.
- Grant latency: 0 cycles from req when the bus is free (gnt is combinational in the same cycle).
- Read latency: rvalid/rdata appear 1 cycle after gnt.
- Write: committed at the clock edge that ends the gnt cycle. A read of the same word in any later cycle returns the new data.
- Throughput: 1 access/cycle. A waiting port is granted within BURST cycles.
- Boundary conditions:
  - Lone requester exceeding BURST keeps getting grants every cycle; cnt saturates at BURST.
  - BURST=1: strict alternation when both ports request.
  - Reset mid-burst: ownership, cnt and any pending rvalid are discarded. After rst falls, arbitration restarts from IDLE with port 0 priority.
  - Same-cycle write by one port and request by the other: only one is granted. The other waits and sees the committed data.

## Test plan
- Reset, then req0 read addr 5 (RAM word 5 = 0xDEADBEEF) -> gnt0 same cycle, ram_read=1, ram_addr=5; next cycle rvalid0=1, rdata0=0xDEADBEEF; rvalid1 stays 0.
- After reset, req0 and req1 both asserted and held (BURST=4) -> gnt0 for 4 cycles, then gnt1 for 4, then gnt0 again; never both gnt high.
- Only req1 held for 10 cycles -> gnt1 all 10 cycles. Then assert req0 -> gnt0 within 1 cycle (cnt already at BURST).
- Port 1 writes 0x12345678 to addr 7; port 0 reads addr 7 in the next cycle -> rdata0=0x12345678, rvalid0 pulse of exactly one cycle.
- Both ports in a burst, rst pulsed mid-burst (including a cycle right after a read grant) -> all outputs 0 immediately, no stale rvalid. After release, port 0 wins the first tie.
- No requests for 5 cycles -> ram_read=ram_write=0, ram_addr=0, fsm IDLE, rdata0/rdata1 unchanged from their last reads.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares a single-port 512x32 data RAM (combinational read, write
//            on the rising edge) between the core load/store port (0) and the
//            program/debug loader port (1). Round-robin arbitration with a
//            bounded burst. Read data returns on a registered path one cycle
//            after the grant.
// Ports    : clk, rst                 - clock, async active-high reset
//            req/we/addr/wdata{0,1}   - requester inputs
//            gnt{0,1}                 - combinational grant (access this cycle)
//            rvalid/rdata{0,1}        - registered read return
//            ram_read/write/addr/wdata, ram_rdata - RAM side
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W = 9,
    parameter int BURST  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [31:0]       wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [31:0]       rdata0,
    output logic [31:0]       rdata1,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int CNT_W = $clog2(BURST) + 1;
    localparam logic [CNT_W-1:0] c_BURST = CNT_W'(BURST);
    localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2
    } state_t;

    state_t           r_fsm_q;
    state_t           w_fsm_d;
    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;
    logic             r_last_q;
    logic             w_last_d;
    logic             r_rvalid0_q;
    logic             w_rvalid0_d;
    logic             r_rvalid1_q;
    logic             w_rvalid1_d;
    logic [31:0]      r_rdata0_q;
    logic [31:0]      w_rdata0_d;
    logic [31:0]      r_rdata1_q;
    logic [31:0]      w_rdata1_d;

    logic             w_arb0;
    logic             w_arb1;
    logic             w_gnt0;
    logic             w_gnt1;
    logic [CNT_W-1:0] w_cnt_inc;

    // Saturating increment of the burst counter.
    assign w_cnt_inc = (r_cnt_q < c_BURST) ? (r_cnt_q + c_ONE) : c_BURST;

    // ------------------------------------------------------------------------
    // Arbitration: next state, counter, last-granted port and raw grants.
    // ------------------------------------------------------------------------
    always_comb begin
        w_fsm_d  = r_fsm_q;
        w_cnt_d  = r_cnt_q;
        w_last_d = r_last_q;
        w_arb0   = 1'b0;
        w_arb1   = 1'b0;
        case (r_fsm_q)
            S_IDLE: begin
                if (req0 && req1) begin
                    // Tie from idle: the port not granted most recently wins.
                    w_arb0 = r_last_q;
                    w_arb1 = ~r_last_q;
                end else begin
                    w_arb0 = req0;
                    w_arb1 = req1;
                end
                if (w_arb0) begin
                    w_fsm_d = S_OWN0;
                    w_cnt_d = c_ONE;
                end else if (w_arb1) begin
                    w_fsm_d = S_OWN1;
                    w_cnt_d = c_ONE;
                end
            end
            S_OWN0: begin
                if (req0 && ((r_cnt_q < c_BURST) || !req1)) begin
                    w_arb0  = 1'b1;
                    w_cnt_d = w_cnt_inc;
                end else if (req1) begin
                    w_arb1  = 1'b1;
                    w_fsm_d = S_OWN1;
                    w_cnt_d = c_ONE;
                end else begin
                    w_fsm_d = S_IDLE;
                    w_cnt_d = '0;
                end
            end
            S_OWN1: begin
                if (req1 && ((r_cnt_q < c_BURST) || !req0)) begin
                    w_arb1  = 1'b1;
                    w_cnt_d = w_cnt_inc;
                end else if (req0) begin
                    w_arb0  = 1'b1;
                    w_fsm_d = S_OWN0;
                    w_cnt_d = c_ONE;
                end else begin
                    w_fsm_d = S_IDLE;
                    w_cnt_d = '0;
                end
            end
            default: begin
                w_fsm_d = S_IDLE;
                w_cnt_d = '0;
            end
        endcase
        if (w_arb0) begin
            w_last_d = 1'b0;
        end else if (w_arb1) begin
            w_last_d = 1'b1;
        end
    end

    // Grants are combinational; suppress them while reset is asserted so the
    // RAM sees no access even mid-cycle.
    assign w_gnt0 = w_arb0 & ~rst;
    assign w_gnt1 = w_arb1 & ~rst;

    // ------------------------------------------------------------------------
    // RAM drive: muxed from the granted port, all zero with no grant.
    // ------------------------------------------------------------------------
    always_comb begin
        ram_read  = 1'b0;
        ram_write = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (w_gnt0) begin
            ram_read  = ~we0;
            ram_write = we0;
            ram_addr  = addr0;
            ram_wdata = we0 ? wdata0 : 32'h0;
        end else if (w_gnt1) begin
            ram_read  = ~we1;
            ram_write = we1;
            ram_addr  = addr1;
            ram_wdata = we1 ? wdata1 : 32'h0;
        end
    end

    // ------------------------------------------------------------------------
    // Read return path: capture on a granted read, rvalid pulses one cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_rvalid0_d = w_gnt0 & ~we0;
        w_rvalid1_d = w_gnt1 & ~we1;
        w_rdata0_d  = w_rvalid0_d ? ram_rdata : r_rdata0_q;
        w_rdata1_d  = w_rvalid1_d ? ram_rdata : r_rdata1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm_q     <= S_IDLE;
            r_cnt_q     <= '0;
            r_last_q    <= 1'b1;
            r_rvalid0_q <= 1'b0;
            r_rvalid1_q <= 1'b0;
            r_rdata0_q  <= 32'h0;
            r_rdata1_q  <= 32'h0;
        end else begin
            r_fsm_q     <= w_fsm_d;
            r_cnt_q     <= w_cnt_d;
            r_last_q    <= w_last_d;
            r_rvalid0_q <= w_rvalid0_d;
            r_rvalid1_q <= w_rvalid1_d;
            r_rdata0_q  <= w_rdata0_d;
            r_rdata1_q  <= w_rdata1_d;
        end
    end

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign rvalid0 = r_rvalid0_q;
    assign rvalid1 = r_rvalid1_q;
    assign rdata0  = r_rdata0_q;
    assign rdata1  = r_rdata1_q;

endmodule
`default_nettype wire
